// File: rtl/seg7_page_display.sv
// seg7_page_display
//
// Latches a 32-bit debug word on a load strobe and shows it on a 4-digit
// multiplexed, active-low 7-segment display as two 16-bit hex pages: the
// high half first, then a fully dark gap, then the low half. The pass
// repeats until the next load or reset. cycle_done pulses once at the end
// of every low page so the surrounding wrapper can step the CPU.
//
// Ports:
//   clk        system clock, everything on posedge
//   reset      synchronous, active-high; wins over every other input
//   value      32-bit word, sampled only while load=1
//   load       single-cycle capture strobe; always restarts at the high page
//   blank      forces the display dark (from the next cycle); timing continues
//   seg        active-low segments, seg[0]=a .. seg[6]=g (registered)
//   dp         active-low decimal point, lit on digit 0 of the high page
//   an         active-low digit enables, an[0] is the rightmost digit
//   page_hi    1 during the high page and the gap that follows it
//   cycle_done one-cycle pulse when the low page hands back to the high page

module seg7_page_display #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int PAGE_CYCLES    = 50000000,
  parameter int GAP_CYCLES     = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        page_hi,
  output logic        cycle_done
);

  // One shared counter times both the pages and the gap, so it must be wide
  // enough for the larger of the two. Widths are clamped to at least 1 bit
  // so a parameter value of 1 still elaborates.
  localparam int RW_RAW = $clog2(REFRESH_CYCLES);
  localparam int PW_RAW = $clog2(PAGE_CYCLES);
  localparam int GW_RAW = $clog2(GAP_CYCLES);
  localparam int RW     = (RW_RAW > 0) ? RW_RAW : 1;
  localparam int CW_MAX = (PW_RAW > GW_RAW) ? PW_RAW : GW_RAW;
  localparam int CW     = (CW_MAX > 0) ? CW_MAX : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] PAGE_LAST    = CW'(PAGE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_HI = 2'd1,
    GAP     = 2'd2,
    SHOW_LO = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          page_end;
  logic          cycle_done_nxt;
  logic [31:0]   latched;
  logic [CW-1:0] page_cnt;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [15:0]   page_word;
  logic [3:0]    nibble;
  logic          showing;

  // Active-low hex font, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next-state logic for the page sequencer. page_end marks the last cycle
  // of the current phase so the shared counter restarts on entry to the
  // next one. A load overrides everything, including the cycle_done that a
  // simultaneous end of the low page would otherwise produce.
  always_comb begin
    state_nxt      = state;
    page_end       = 1'b0;
    cycle_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      SHOW_HI: begin
        if (page_cnt == PAGE_LAST) begin
          state_nxt = GAP;
          page_end  = 1'b1;
        end
      end
      GAP: begin
        if (page_cnt == GAP_LAST) begin
          state_nxt = SHOW_LO;
          page_end  = 1'b1;
        end
      end
      SHOW_LO: begin
        if (page_cnt == PAGE_LAST) begin
          state_nxt      = SHOW_HI;
          page_end       = 1'b1;
          cycle_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (load) begin
      state_nxt      = SHOW_HI;
      cycle_done_nxt = 1'b0;
    end
  end

  // State register. cycle_done is registered so it is high in the first
  // cycle of the new high page, i.e. the cycle the transition lands in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cycle_done <= cycle_done_nxt;
    end
  end

  // Captured word and timing counters. The digit scan free-runs in every
  // non-idle state (gap and blanking included) so the refresh cadence never
  // depends on what is being shown; only a load or reset realigns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      latched     <= '0;
      page_cnt    <= '0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (load) begin
      latched     <= value;
      page_cnt    <= '0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (state != IDLE) begin
      if (page_end) begin
        page_cnt <= '0;
      end else begin
        page_cnt <= page_cnt + 1'b1;
      end
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Pick the half-word for the current page and the nibble for the digit
  // currently being scanned.
  always_comb begin
    page_word = (state == SHOW_HI) ? latched[31:16] : latched[15:0];
    nibble    = page_word[{digit_idx, 2'b00} +: 4];
    showing   = (state == SHOW_HI) || (state == SHOW_LO);
  end

  // Registered display drivers: they follow state/digit_idx one cycle late,
  // which keeps the pad outputs glitch-free.
  always_ff @(posedge clk) begin
    if (reset || blank || !showing) begin
      seg <= 7'h7F;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= hex_to_seg(nibble);
      an  <= ~(4'b0001 << digit_idx);
      dp  <= ~((state == SHOW_HI) && (digit_idx == 2'd0));
    end
  end

  assign page_hi = (state == SHOW_HI) || (state == GAP);

endmodule

// File: tb/tb_seg7_page_display.sv
// tb_seg7_page_display
//
// Self-checking bench for seg7_page_display with small timing parameters.
// A reference model tracks the time elapsed since the last load and derives
// page, gap and digit from it arithmetically; each clock it pushes the
// expected outputs for the following cycle into a queue that a separate
// monitor drains on the falling edge. Directed checks pin a few values
// from the hex font and the pass timing to constants.

module tb_seg7_page_display;

  localparam int REFRESH = 4;
  localparam int PAGE    = 32;
  localparam int GAPLEN  = 8;
  localparam int PASS    = 2 * PAGE + GAPLEN;

  logic        clk;
  logic        reset;
  logic [31:0] value;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        page_hi;
  logic        cycle_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       page_hi;
    logic       cycle_done;
  } exp_t;

  exp_t exp_q[$];

  seg7_page_display #(
    .REFRESH_CYCLES(REFRESH),
    .PAGE_CYCLES   (PAGE),
    .GAP_CYCLES    (GAPLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank     (blank),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .page_hi   (page_hi),
    .cycle_done(cycle_done)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hex font (gfedcba, active low) indexed by digit value.
  logic [6:0] hex_tab [0:15];
  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: m_t is the number of cycles since the pass started.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [31:0] m_latched = '0;
  int          m_phase;
  int          m_digit;
  bit          m_hi;
  bit          m_gap;
  int          m_nib;
  exp_t        m_e;

  always @(posedge clk) begin
    m_phase = m_t % PASS;
    m_digit = (m_t / REFRESH) % 4;
    m_hi    = m_active && (m_phase < PAGE);
    m_gap   = m_active && (m_phase >= PAGE) && (m_phase < PAGE + GAPLEN);
    if (reset || blank || !m_active || m_gap) begin
      m_e.seg = 7'h7F;
      m_e.an  = 4'hF;
      m_e.dp  = 1'b1;
    end else begin
      m_nib   = int'((m_latched >> ((m_hi ? 16 : 0) + 4 * m_digit)) & 32'hF);
      m_e.seg = hex_tab[m_nib];
      m_e.an  = 4'hF & ~(4'h1 << m_digit);
      m_e.dp  = !(m_hi && (m_digit == 0));
    end
    if (reset) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (load) begin
      m_active  = 1'b1;
      m_t       = 0;
      m_latched = value;
    end else if (m_active) begin
      m_t++;
    end
    m_e.page_hi    = m_active && ((m_t % PASS) < PAGE + GAPLEN);
    m_e.cycle_done = m_active && (m_t > 0) && ((m_t % PASS) == 0);
    exp_q.push_back(m_e);
  end

  // Monitor: every cycle the DUT presents a fresh set of outputs; compare
  // them mid-cycle against the oldest queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("sb_seg", 32'(seg), 32'(mon_e.seg));
      checkOutput("sb_an", 32'(an), 32'(mon_e.an));
      checkOutput("sb_dp", 32'(dp), 32'(mon_e.dp));
      checkOutput("sb_page_hi", 32'(page_hi), 32'(mon_e.page_hi));
      checkOutput("sb_cycle_done", 32'(cycle_done), 32'(mon_e.cycle_done));
    end
  end

  // Drive the inputs and hold them for n cycles; returns 1 time unit after
  // the last rising edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [31:0] v,
                               input logic b, input int n);
    reset = r;
    load  = l;
    value = v;
    blank = b;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step until cycle_done is seen, bounded so a stuck design cannot hang.
  task automatic waitDone(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (cycle_done !== 1'b1 && k < 4 * PASS);
  endtask

  int k;
  logic cur_blank;

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    blank = 1'b0;

    // Reset, then idle with no load: dark, no pulses.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 3);
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 100);
    checkOutput("idle_an", 32'(an), 32'hF);
    checkOutput("idle_page_hi", 32'(page_hi), 32'h0);

    // Basic pass and cycle_done timing.
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("hi_digit0_seg", 32'(seg), 32'h19);
    checkOutput("hi_digit0_an", 32'(an), 32'hE);
    checkOutput("hi_digit0_dp", 32'(dp), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 4);
    checkOutput("hi_digit1_seg", 32'(seg), 32'h30);
    checkOutput("hi_digit1_an", 32'(an), 32'hD);
    waitDone(k);
    checkOutput("done_latency", 32'(k + 5), 32'd72);
    waitDone(k);
    checkOutput("done_period", 32'(k), 32'd72);

    // Value changes after the load are ignored.
    applyStimulus(1'b0, 1'b1, 32'hFFFF0000, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("hiF_seg", 32'(seg), 32'h0E);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 40);
    checkOutput("lo0_seg", 32'(seg), 32'h40);
    checkOutput("lo0_dp", 32'(dp), 32'h1);
    checkOutput("lo0_page_hi", 32'(page_hi), 32'h0);

    // Blank for 10 cycles during the high page.
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("blank_seg", 32'(seg), 32'h7F);
    checkOutput("blank_an", 32'(an), 32'hF);
    checkOutput("blank_page_hi", 32'(page_hi), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 9);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 0);
    waitDone(k);
    checkOutput("blank_done_latency", 32'(k + 14), 32'd72);
    waitDone(k);
    checkOutput("blank_done_period", 32'(k), 32'd72);

    // Load on the final low-page cycle suppresses cycle_done.
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 71);
    checkOutput("last_lo_page_hi", 32'(page_hi), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h00000008, 1'b0, 1);
    checkOutput("load_wins_no_done", 32'(cycle_done), 32'h0);
    checkOutput("load_wins_page_hi", 32'(page_hi), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("restart_seg", 32'(seg), 32'h40);
    checkOutput("restart_dp", 32'(dp), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 48);
    checkOutput("lo8_seg", 32'(seg), 32'h00);
    checkOutput("lo8_an", 32'(an), 32'hE);

    // Reset in the middle of the gap, then a clean restart.
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 34);
    checkOutput("gap_page_hi", 32'(page_hi), 32'h1);
    checkOutput("gap_an", 32'(an), 32'hF);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("midgap_reset_page_hi", 32'(page_hi), 32'h0);
    checkOutput("midgap_reset_seg", 32'(seg), 32'h7F);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("reload_seg", 32'(seg), 32'h19);
    waitDone(k);
    checkOutput("reload_done_latency", 32'(k + 1), 32'd72);

    // Randomized traffic: sparse loads and resets, toggling blank, noisy value.
    cur_blank = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cur_blank = ~cur_blank;
      applyStimulus(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                    $urandom, cur_blank, 1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
